// File: rtl/user_core_bus_pkg.sv
// Shared types and widths for the user core bus arbiter.
//   req_id_e    : requester identity stored in the ID FIFO
//   arb_state_e : arbiter FSM states
package user_core_bus_pkg;

   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned BeWidth   = 4;

   typedef enum logic {
      REQ_INSTR = 1'b0,
      REQ_DATA  = 1'b1
   } req_id_e;

   typedef enum logic {
      ARB,
      WAIT_GNT
   } arb_state_e;

endpackage

// File: rtl/user_core_bus_arb_if.sv
// req/gnt/rvalid bus bundle used for the instr, data and memory-side ports.
//   master : issues req/we/be/addr/wdata, receives gnt/rvalid/rdata/err
//   slave  : the opposite direction
interface user_core_bus_arb_if;
   import user_core_bus_pkg::*;

   logic                 req;
   logic                 gnt;
   logic                 rvalid;
   logic                 we;
   logic [BeWidth-1:0]   be;
   logic [AddrWidth-1:0] addr;
   logic [DataWidth-1:0] wdata;
   logic [DataWidth-1:0] rdata;
   logic                 err;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/user_core_id_fifo.sv
// In-order 1-bit ID FIFO of parameterised depth.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push, din    : write din (accepted when not full, or when popping)
//   pop          : drop the head entry (ignored when empty)
//   full, empty  : occupancy flags
//   head         : oldest stored entry
module user_core_id_fifo #(
   parameter int unsigned Depth = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push,
   input  logic pop,
   input  logic din,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Depth-1:0] mem_q;
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             push_ok;
   logic             pop_ok;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full  = (cnt_q == CntW'(Depth));
   assign empty = (cnt_q == '0);
   assign head  = mem_q[rd_ptr_q];

   // A pop frees the head slot this cycle, so a push into a full FIFO is legal alongside it.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/user_core_bus_arb.sv
// Two-requester arbiter sharing one memory-side req/gnt/rvalid port between
// the instruction and data interfaces of the user core.
//   clk_i, rst_i : clock, synchronous active-high reset
//   instr        : instruction port (read-only), slave side
//   data         : data port, slave side
//   mem          : memory-side request/response, master side
//   proto_err_o  : sticky, set by an rvalid with nothing outstanding
module user_core_bus_arb
   import user_core_bus_pkg::*;
#(
   parameter int unsigned MaxOutstanding = 2,
   parameter int unsigned StarveLimit    = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   user_core_bus_arb_if.slave   instr,
   user_core_bus_arb_if.slave   data,
   user_core_bus_arb_if.master  mem,
   output logic                 proto_err_o
);

   localparam logic [7:0] StarveMax = 8'(StarveLimit);

   arb_state_e state_q, state_d;
   req_id_e    sel, sel_q;
   logic [7:0] starve_cnt_q;
   logic       proto_err_q;
   logic       m_req;
   logic       grant;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_head;
   logic       resp_ok;
   req_id_e    resp_id;

   // Selection, request eligibility and next state.
   always_comb begin
      state_d = state_q;
      sel     = sel_q;
      m_req   = 1'b0;
      if (state_q == WAIT_GNT) begin
         // Locked: the pending request stays on the bus unchanged until granted.
         sel   = sel_q;
         m_req = 1'b1;
         if (mem.gnt) begin
            state_d = ARB;
         end
      end else begin
         sel   = (!data.req || (starve_cnt_q >= StarveMax)) ? REQ_INSTR : REQ_DATA;
         m_req = (instr.req | data.req) & ~fifo_full;
         if (m_req && !mem.gnt) begin
            state_d = WAIT_GNT;
         end
      end
   end

   assign grant = mem.gnt & m_req;

   assign mem.req   = m_req;
   assign mem.we    = (sel == REQ_DATA) ? data.we    : 1'b0;
   assign mem.be    = (sel == REQ_DATA) ? data.be    : '1;
   assign mem.addr  = (sel == REQ_DATA) ? data.addr  : instr.addr;
   assign mem.wdata = (sel == REQ_DATA) ? data.wdata : '0;

   assign instr.gnt = grant & (sel == REQ_INSTR);
   assign data.gnt  = grant & (sel == REQ_DATA);

   // Response routing by the ID of the oldest outstanding grant.
   assign resp_ok = mem.rvalid & ~fifo_empty;
   assign resp_id = req_id_e'(fifo_head);

   assign instr.rvalid = resp_ok & (resp_id == REQ_INSTR);
   assign data.rvalid  = resp_ok & (resp_id == REQ_DATA);
   assign instr.rdata  = instr.rvalid ? mem.rdata : '0;
   assign data.rdata   = data.rvalid  ? mem.rdata : '0;
   assign instr.err    = instr.rvalid & mem.err;
   assign data.err     = data.rvalid  & mem.err;

   assign proto_err_o = proto_err_q;

   user_core_id_fifo #(
      .Depth (MaxOutstanding)
   ) u_id_fifo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (grant),
      .pop   (mem.rvalid),
      .din   (sel),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB;
         sel_q   <= REQ_INSTR;
      end else begin
         state_q <= state_d;
         if (state_q == ARB && state_d == WAIT_GNT) begin
            sel_q <= sel;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt_q <= '0;
      end else if (!instr.req || instr.gnt) begin
         starve_cnt_q <= '0;
      end else if (starve_cnt_q < StarveMax) begin
         starve_cnt_q <= starve_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         proto_err_q <= 1'b0;
      end else if (mem.rvalid && fifo_empty) begin
         proto_err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_user_core_bus_arb.sv
// Directed bench for user_core_bus_arb: a cycle-by-cycle vector table plus
// hand-written sequences for gnt stall, starvation, reset and FIFO corners.
module tb_user_core_bus_arb;
   import user_core_bus_pkg::*;

   localparam logic [31:0] IAddr  = 32'h2000_0000;
   localparam logic [31:0] DAddr  = 32'h3000_0010;
   localparam logic [3:0]  DBe    = 4'h3;
   localparam logic [31:0] DWdata = 32'hCAFE_F00D;

   logic clk = 1'b0;
   logic rst;
   logic proto_err;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   user_core_bus_arb_if instr_bus ();
   user_core_bus_arb_if data_bus ();
   user_core_bus_arb_if mem_bus ();

   user_core_bus_arb #(
      .MaxOutstanding (2),
      .StarveLimit    (8)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .instr       (instr_bus),
      .data        (data_bus),
      .mem         (mem_bus),
      .proto_err_o (proto_err)
   );

   // Standalone FIFO for push+pop while full.
   logic f_push, f_pop, f_din, f_full, f_empty, f_head;

   user_core_id_fifo #(
      .Depth (2)
   ) u_fifo (
      .clk_i (clk),
      .rst_i (rst),
      .push  (f_push),
      .pop   (f_pop),
      .din   (f_din),
      .full  (f_full),
      .empty (f_empty),
      .head  (f_head)
   );

   typedef struct {
      logic        ir, dr, dwe, gnt, rv;
      logic [31:0] rdata;
      logic        e_mreq, e_ig, e_dg, e_irv, e_drv, e_we, e_perr;
      logic [31:0] e_ird, e_drd;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(
      input logic ir, dr, dwe, gnt, rv, input logic [31:0] rdata,
      input logic e_mreq, e_ig, e_dg, e_irv, e_drv, e_we, e_perr,
      input logic [31:0] e_ird, e_drd);
      vec_t v;
      v.ir = ir; v.dr = dr; v.dwe = dwe; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
      v.e_mreq = e_mreq; v.e_ig = e_ig; v.e_dg = e_dg; v.e_irv = e_irv;
      v.e_drv = e_drv; v.e_we = e_we; v.e_perr = e_perr;
      v.e_ird = e_ird; v.e_drd = e_drd;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic clear_inputs();
      instr_bus.req = 1'b0; instr_bus.we = 1'b0; instr_bus.be = '0;
      instr_bus.addr = IAddr; instr_bus.wdata = '0;
      data_bus.req = 1'b0; data_bus.we = 1'b0; data_bus.be = DBe;
      data_bus.addr = DAddr; data_bus.wdata = DWdata;
      mem_bus.gnt = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0; mem_bus.err = 1'b0;
      f_push = 1'b0; f_pop = 1'b0; f_din = 1'b0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic chk_bus(input string nm, input logic mreq, ig, dg);
      chk({nm, "_mreq"}, 32'(mem_bus.req), 32'(mreq));
      chk({nm, "_igtn"}, 32'(instr_bus.gnt), 32'(ig));
      chk({nm, "_dgnt"}, 32'(data_bus.gnt), 32'(dg));
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      next_cycle();
      #2;
      chk_bus("in_reset", 1'b0, 1'b0, 1'b0);
      chk("in_reset_perr", 32'(proto_err), 32'd0);
      rst = 1'b0;
      next_cycle();
      #2;
      chk_bus("after_reset", 1'b0, 1'b0, 1'b0);
      chk("after_reset_irv", 32'(instr_bus.rvalid), 32'd0);
      chk("after_reset_drv", 32'(data_bus.rvalid), 32'd0);
      chk("after_reset_perr", 32'(proto_err), 32'd0);
      chk("fifo_reset_empty", 32'(f_empty), 32'd1);
      next_cycle();

      //              ir dr we gn rv rdata          mreq ig dg irv drv we perr ird            drd
      vecs[0]  = mk(1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0);
      vecs[1]  = mk(0, 0, 0, 0, 1, 32'hDEADBEEF,   0, 0, 0, 1, 0, 0, 0, 32'hDEADBEEF,   32'h0);
      vecs[2]  = mk(1, 1, 1, 1, 0, 32'h0,          1, 0, 1, 0, 0, 1, 0, 32'h0,          32'h0);
      vecs[3]  = mk(1, 0, 1, 1, 1, 32'h1,          1, 1, 0, 0, 1, 0, 0, 32'h0,          32'h1);
      vecs[4]  = mk(0, 0, 0, 0, 1, 32'h2,          0, 0, 0, 1, 0, 0, 0, 32'h2,          32'h0);
      vecs[5]  = mk(1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0);
      vecs[6]  = mk(1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0);
      vecs[7]  = mk(1, 0, 0, 1, 0, 32'h0,          0, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0);
      vecs[8]  = mk(1, 0, 0, 1, 1, 32'h5,          0, 0, 0, 1, 0, 0, 0, 32'h5,          32'h0);
      vecs[9]  = mk(1, 0, 0, 1, 1, 32'h6,          1, 1, 0, 1, 0, 0, 0, 32'h6,          32'h0);
      vecs[10] = mk(1, 0, 0, 1, 0, 32'h0,          1, 1, 0, 0, 0, 0, 0, 32'h0,          32'h0);
      vecs[11] = mk(0, 0, 0, 0, 1, 32'h7,          0, 0, 0, 1, 0, 0, 0, 32'h7,          32'h0);
      vecs[12] = mk(0, 0, 0, 0, 1, 32'h8,          0, 0, 0, 1, 0, 0, 0, 32'h8,          32'h0);
      vecs[13] = mk(0, 0, 0, 0, 1, 32'h9,          0, 0, 0, 0, 0, 0, 0, 32'h0,          32'h0);
      vecs[14] = mk(0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 0, 0, 0, 1, 32'h0,          32'h0);

      for (int i = 0; i < 15; i++) begin
         instr_bus.req = vecs[i].ir;
         data_bus.req  = vecs[i].dr;
         data_bus.we   = vecs[i].dwe;
         mem_bus.gnt   = vecs[i].gnt;
         mem_bus.rvalid = vecs[i].rv;
         mem_bus.rdata = vecs[i].rdata;
         #2;
         chk_bus($sformatf("v%0d", i), vecs[i].e_mreq, vecs[i].e_ig, vecs[i].e_dg);
         chk($sformatf("v%0d_irv", i), 32'(instr_bus.rvalid), 32'(vecs[i].e_irv));
         chk($sformatf("v%0d_drv", i), 32'(data_bus.rvalid), 32'(vecs[i].e_drv));
         chk($sformatf("v%0d_ird", i), instr_bus.rdata, vecs[i].e_ird);
         chk($sformatf("v%0d_drd", i), data_bus.rdata, vecs[i].e_drd);
         chk($sformatf("v%0d_perr", i), 32'(proto_err), 32'(vecs[i].e_perr));
         if (vecs[i].e_mreq) chk($sformatf("v%0d_we", i), 32'(mem_bus.we), 32'(vecs[i].e_we));
         if (vecs[i].e_ig) begin
            chk($sformatf("v%0d_iaddr", i), mem_bus.addr, IAddr);
            chk($sformatf("v%0d_ibe", i), 32'(mem_bus.be), 32'hF);
            chk($sformatf("v%0d_iwd", i), mem_bus.wdata, 32'h0);
         end
         if (vecs[i].e_dg) begin
            chk($sformatf("v%0d_daddr", i), mem_bus.addr, DAddr);
            chk($sformatf("v%0d_dbe", i), 32'(mem_bus.be), 32'(DBe));
            chk($sformatf("v%0d_dwd", i), mem_bus.wdata, DWdata);
         end
         next_cycle();
      end

      // Gnt stall: data locked for 3 cycles, then granted; instr follows.
      do_reset();
      instr_bus.req = 1'b1; data_bus.req = 1'b1; data_bus.we = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         chk_bus($sformatf("stall%0d", c), 1'b1, 1'b0, 1'b0);
         chk($sformatf("stall%0d_addr", c), mem_bus.addr, DAddr);
         chk($sformatf("stall%0d_we", c), 32'(mem_bus.we), 32'd1);
         chk($sformatf("stall%0d_be", c), 32'(mem_bus.be), 32'(DBe));
         next_cycle();
      end
      mem_bus.gnt = 1'b1;
      #2;
      chk_bus("stall_gnt", 1'b1, 1'b0, 1'b1);
      chk("stall_gnt_addr", mem_bus.addr, DAddr);
      next_cycle();
      data_bus.req = 1'b0; data_bus.we = 1'b0;
      #2;
      chk_bus("stall_instr", 1'b1, 1'b1, 1'b0);
      chk("stall_instr_addr", mem_bus.addr, IAddr);
      next_cycle();

      // Reset with two IDs outstanding; late rvalid is then stray.
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h55;
      #2;
      chk("late_irv", 32'(instr_bus.rvalid), 32'd0);
      chk("late_drv", 32'(data_bus.rvalid), 32'd0);
      chk("late_perr_pre", 32'(proto_err), 32'd0);
      next_cycle();
      mem_bus.rvalid = 1'b0;
      #2;
      chk("late_perr", 32'(proto_err), 32'd1);
      next_cycle();
      do_reset();
      instr_bus.req = 1'b1; mem_bus.gnt = 1'b1;
      #2;
      chk("rst_clear_perr", 32'(proto_err), 32'd0);
      chk_bus("rst_first_gnt", 1'b1, 1'b1, 1'b0);
      next_cycle();

      // Starvation: instr forced through on the 9th cycle, counter clears after.
      do_reset();
      instr_bus.req = 1'b1; data_bus.req = 1'b1; mem_bus.gnt = 1'b1;
      for (int k = 0; k < 10; k++) begin
         mem_bus.rvalid = (k >= 1);
         mem_bus.rdata  = 32'(k);
         #2;
         chk_bus($sformatf("starve%0d", k), 1'b1, (k == 8), (k != 8));
         if (k >= 1) begin
            chk($sformatf("starve%0d_irv", k), 32'(instr_bus.rvalid), 32'(k == 9));
            chk($sformatf("starve%0d_drv", k), 32'(data_bus.rvalid), 32'(k != 9));
         end
         next_cycle();
      end

      // FIFO push+pop while full keeps it full and advances the head.
      do_reset();
      f_push = 1'b1; f_din = 1'b1;
      next_cycle();
      f_din = 1'b0;
      next_cycle();
      #2;
      chk("fifo_full", 32'(f_full), 32'd1);
      chk("fifo_head0", 32'(f_head), 32'd1);
      f_din = 1'b1; f_pop = 1'b1;
      next_cycle();
      #2;
      chk("fifo_pp_full", 32'(f_full), 32'd1);
      chk("fifo_pp_head", 32'(f_head), 32'd0);
      f_push = 1'b0;
      next_cycle();
      #2;
      chk("fifo_pop_full", 32'(f_full), 32'd0);
      chk("fifo_pop_head", 32'(f_head), 32'd1);
      next_cycle();
      #2;
      chk("fifo_empty", 32'(f_empty), 32'd1);
      f_pop = 1'b0;
      next_cycle();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
